// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch time counter.
// time_t packs the six BCD digits in display order, minutes tens first.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
        bcd_t cs_t;
        bcd_t cs_o;
    } time_t;

    localparam time_t TIME_ZERO = 24'h00_00_00;
    localparam bcd_t  SEC_T_MAX = 4'd5;
    localparam bcd_t  MIN_T_MAX = 4'd5;
    localparam bcd_t  DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MAX. The carry is combinational so that a whole chain
// of digits rolls over in the same clock edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    bcd_t q_q;
    bcd_t q_d;

    // Next digit value; an out-of-range value wraps to zero on its next increment
    always_comb begin
        q_d = q_q;
        if (inc) begin
            if (q_q >= MAX) begin
                q_d = 4'd0;
            end else begin
                q_d = q_q + 4'd1;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// MM:SS.cc stopwatch count advanced at TICK_HZ while en is high, with lap freeze
// and a wrap pulse when the count rolls over from 59:59.99.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  lap_toggle,
    output time_t disp,
    output logic  lap_active,
    output logic  tick,
    output logic  wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          step_s;

    time_t live_s;
    logic  carry_cs_o_s;
    logic  carry_cs_t_s;
    logic  carry_sec_o_s;
    logic  carry_sec_t_s;
    logic  carry_min_o_s;
    logic  carry_min_t_s;

    time_t lap_q;
    time_t lap_d;
    logic  lap_active_q;
    logic  lap_active_d;
    logic  tick_q;
    logic  wrap_q;

    // Prescaler: holds its phase while paused so resume loses no partial period
    always_comb begin
        presc_d = presc_q;
        step_s  = 1'b0;
        if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                step_s  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
                step_s  = 1'b0;
            end
        end else begin
            presc_d = presc_q;
            step_s  = 1'b0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_o (
        .clk(clk), .rst(rst), .inc(step_s),
        .q(live_s.cs_o), .carry(carry_cs_o_s)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_t (
        .clk(clk), .rst(rst), .inc(carry_cs_o_s),
        .q(live_s.cs_t), .carry(carry_cs_t_s)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_o (
        .clk(clk), .rst(rst), .inc(carry_cs_t_s),
        .q(live_s.sec_o), .carry(carry_sec_o_s)
    );

    bcd_digit_counter #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(clk), .rst(rst), .inc(carry_sec_o_s),
        .q(live_s.sec_t), .carry(carry_sec_t_s)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_o (
        .clk(clk), .rst(rst), .inc(carry_sec_t_s),
        .q(live_s.min_o), .carry(carry_min_o_s)
    );

    // A carry out of the top digit is exactly the 59:59.99 -> 00:00.00 step
    bcd_digit_counter #(.MAX(MIN_T_MAX)) u_min_t (
        .clk(clk), .rst(rst), .inc(carry_min_o_s),
        .q(live_s.min_t), .carry(carry_min_t_s)
    );

    // Lap capture takes the live value present before this edge's increment
    always_comb begin
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        if (lap_toggle) begin
            if (!lap_active_q) begin
                lap_d        = live_s;
                lap_active_d = 1'b1;
            end else begin
                lap_active_d = 1'b0;
            end
        end else begin
            lap_active_d = lap_active_q;
        end
    end

    // Lap and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q        <= TIME_ZERO;
            lap_active_q <= 1'b0;
            tick_q       <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            tick_q       <= step_s;
            wrap_q       <= carry_min_t_s;
        end
    end

    assign disp       = lap_active_q ? lap_q : live_s;
    assign lap_active = lap_active_q;
    assign tick       = tick_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench: integer-centisecond reference model checked against the DUT every cycle,
// directed scenarios with literal expectations, then randomized en/lap/rst traffic.
module tb_stopwatch_time_counter;

    localparam int DIV     = 10;
    localparam int FULL_CS = 360000;

    logic        clk;
    logic        rst;
    logic        en;
    logic        lap_toggle;
    logic [23:0] disp;
    logic        lap_active;
    logic        tick;
    logic        wrap;

    int n_chk  = 0;
    int n_fail = 0;

    int   m_presc;
    int   m_live;
    int   m_lap;
    logic m_la;
    logic m_tick;
    logic m_wrap;
    logic model_ok = 1'b0;

    logic [23:0] pre_d;

    stopwatch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .en(en), .lap_toggle(lap_toggle),
        .disp(disp), .lap_active(lap_active), .tick(tick), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int c);
        int m;
        int s;
        int h;
        m = c / 6000;
        s = (c / 100) % 60;
        h = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model in plain centisecond arithmetic
    always @(posedge clk) begin
        if (rst) begin
            m_presc  = 0;
            m_live   = 0;
            m_lap    = 0;
            m_la     = 1'b0;
            m_tick   = 1'b0;
            m_wrap   = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_tick = 1'b0;
            m_wrap = 1'b0;
            if (lap_toggle) begin
                if (!m_la) begin
                    m_lap = m_live;
                    m_la  = 1'b1;
                end else begin
                    m_la = 1'b0;
                end
            end
            if (en) begin
                if (m_presc == DIV - 1) begin
                    m_presc = 0;
                    m_live  = (m_live + 1) % FULL_CS;
                    m_tick  = 1'b1;
                    m_wrap  = (m_live == 0);
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("disp", disp, to_bcd(m_la ? m_lap : m_live));
            chk("lap_active", {23'd0, lap_active}, {23'd0, m_la});
            chk("tick", {23'd0, tick}, {23'd0, m_tick});
            chk("wrap", {23'd0, wrap}, {23'd0, m_wrap});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lap_toggle = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic pulse_lap();
        lap_toggle = 1'b1;
        cyc(1);
        lap_toggle = 1'b0;
    endtask

    // Deposit a live count into the digit registers (called at a negedge)
    task automatic preload(input int c);
        pre_d = to_bcd(c);
        force dut.u_min_t.q_q = pre_d[23:20];
        force dut.u_min_o.q_q = pre_d[19:16];
        force dut.u_sec_t.q_q = pre_d[15:12];
        force dut.u_sec_o.q_q = pre_d[11:8];
        force dut.u_cs_t.q_q  = pre_d[7:4];
        force dut.u_cs_o.q_q  = pre_d[3:0];
        m_live = c;
        #1;
        release dut.u_min_t.q_q;
        release dut.u_min_o.q_q;
        release dut.u_sec_t.q_q;
        release dut.u_sec_o.q_q;
        release dut.u_cs_t.q_q;
        release dut.u_cs_o.q_q;
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        lap_toggle = 1'b0;
        cyc(1);

        // 1: reset state, first tick latency, 1.00 s
        en = 1'b1;
        do_reset();
        chk("t1_reset_disp", disp, 24'h000000);
        chk("t1_reset_flags", {21'd0, lap_active, tick, wrap}, 24'h000000);
        cyc(9);
        chk("t1_no_tick_yet", {23'd0, tick}, 24'h000000);
        cyc(1);
        chk("t1_first_tick", {23'd0, tick}, 24'h000001);
        chk("t1_disp_001", disp, 24'h000001);
        cyc(990);
        chk("t1_disp_100", disp, 24'h000100);

        // 2: pause keeps prescaler phase
        do_reset();
        en = 1'b1; cyc(5);
        en = 1'b0; cyc(20);
        en = 1'b1; cyc(4);
        chk("t2_no_tick", {23'd0, tick}, 24'h000000);
        cyc(1);
        chk("t2_tick", {23'd0, tick}, 24'h000001);
        chk("t2_disp", disp, 24'h000001);

        // 3: wrap from 59:59.99
        en = 1'b0;
        do_reset();
        preload(359999);
        cyc(1);
        chk("t3_preload", disp, 24'h595999);
        en = 1'b1;
        cyc(10);
        chk("t3_wrap_disp", disp, 24'h000000);
        chk("t3_wrap_pulse", {22'd0, wrap, tick}, 24'h000003);
        cyc(1);
        chk("t3_wrap_low", {22'd0, wrap, tick}, 24'h000000);

        // 4: lap hold for 50 ticks
        do_reset();
        en = 1'b1;
        cyc(420);
        chk("t4_live42", disp, 24'h000042);
        pulse_lap();
        chk("t4_lap_on", {23'd0, lap_active}, 24'h000001);
        cyc(499);
        chk("t4_frozen", disp, 24'h000042);
        pulse_lap();
        chk("t4_live92", disp, 24'h000092);
        chk("t4_lap_off", {23'd0, lap_active}, 24'h000000);

        // 5: lap capture on a tick edge takes the pre-increment value
        do_reset();
        cyc(79);
        pulse_lap();
        chk("t5_captured", disp, 24'h000007);
        chk("t5_tick", {23'd0, tick}, 24'h000001);
        pulse_lap();
        chk("t5_live08", disp, 24'h000008);

        // 6: reset mid-count with lap held
        do_reset();
        cyc(3);
        pulse_lap();
        cyc(2);
        do_reset();
        chk("t6_disp", disp, 24'h000000);
        chk("t6_flags", {21'd0, lap_active, tick, wrap}, 24'h000000);
        cyc(10);
        chk("t6_tick", {23'd0, tick}, 24'h000001);
        chk("t6_disp1", disp, 24'h000001);

        // Randomized traffic, with near-wrap preloads to exercise carries
        do_reset();
        preload(359985);
        for (int i = 0; i < 3000; i++) begin
            en         = (($urandom % 4) != 0);
            lap_toggle = (($urandom % 20) == 0);
            rst        = (($urandom % 600) == 0);
            if (i == 1500) begin
                preload(359950);
            end
            cyc(1);
        end
        rst = 1'b0;
        en = 1'b0;
        lap_toggle = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
